// File: rtl/port_event_fifo.sv
// Port-mapped byte FIFO on the MCU I/O bus: source bytes are queued, the MCU reads head/status and writes control.
// Optional build macro PEF_OVERWRITE_EN: when full, a new byte overwrites the oldest instead of being refused.
module port_event_fifo #(
  parameter int unsigned DEPTH     = 8,
  parameter logic [7:0]  DATA_ID   = 8'h30,
  parameter logic [7:0]  STATUS_ID = 8'h31,
  parameter logic [7:0]  CTRL_ID   = 8'h32
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_DATA,
  output logic       IN_HIT,
  input  logic [7:0] SRC_DATA,
  input  logic       SRC_VALID,
  output logic       SRC_READY,
  output logic       INTR
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          int_en_q, int_en_d;
  logic          intr_q, intr_d;

  logic       full, empty, ctrl_wr, pop_req, clr_ovf, flush;
  logic       do_push, do_pop, ovr_drop, ovf_evt;
  logic [3:0] ctrl_unused;
  logic [7:0] status;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign ctrl_wr     = IO_STRB && (PORT_ID == CTRL_ID);
  assign pop_req     = ctrl_wr && OUT_PORT[0];
  assign clr_ovf     = ctrl_wr && OUT_PORT[1];
  assign flush       = ctrl_wr && OUT_PORT[2];
  assign ctrl_unused = OUT_PORT[7:4];
  assign do_pop      = pop_req && !empty;

`ifdef PEF_OVERWRITE_EN
  // Full and no pop: the new byte replaces the oldest, both pointers advance.
  assign SRC_READY = 1'b1;
  assign do_push   = SRC_VALID;
  assign ovr_drop  = SRC_VALID && full && !do_pop;
  assign ovf_evt   = ovr_drop;
`else
  assign SRC_READY = !full;
  assign do_push   = SRC_VALID && !full;
  assign ovr_drop  = 1'b0;
  assign ovf_evt   = SRC_VALID && full;
`endif

  assign status  = {full, empty, ovf_q, int_en_q, 4'(count_q)};
  assign IN_HIT  = (PORT_ID == DATA_ID) || (PORT_ID == STATUS_ID);
  assign INTR    = intr_q;

  always_comb begin
    IN_DATA = 8'h00;
    if (PORT_ID == DATA_ID) begin
      IN_DATA = empty ? 8'h00 : mem_q[rd_ptr_q];
    end else if (PORT_ID == STATUS_ID) begin
      IN_DATA = status;
    end
  end

  // Next-state: flush overrides push/pop; overflow and int_en are independent of flush.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = (ovf_q && !clr_ovf) || ovf_evt;
    int_en_d = ctrl_wr ? OUT_PORT[3] : int_en_q;
    intr_d   = 1'b0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = SRC_DATA;
        wr_ptr_d        = PW'(wr_ptr_q + 1'b1);
      end
      if (do_pop || ovr_drop) begin
        rd_ptr_d = PW'(rd_ptr_q + 1'b1);
      end
      if (do_push && !do_pop && !ovr_drop) begin
        count_d = CW'(count_q + 1'b1);
      end else if (do_pop && !do_push) begin
        count_d = CW'(count_q - 1'b1);
      end
      intr_d = int_en_q && ((do_push && empty) || (do_pop && (count_d != '0)));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      int_en_q <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      int_en_q <= int_en_d;
      intr_q   <= intr_d;
    end
  end

endmodule

// File: tb/tb_port_event_fifo.sv
// Directed self-checking bench for port_event_fifo; expectations follow PEF_OVERWRITE_EN when defined.
module tb_port_event_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] port_id, out_port, in_data, src_data;
  logic       io_strb, in_hit, src_valid, src_ready, intr;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PEF_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  port_event_fifo dut (
    .CLK(clk), .RESET(rst), .PORT_ID(port_id), .OUT_PORT(out_port), .IO_STRB(io_strb),
    .IN_DATA(in_data), .IN_HIT(in_hit), .SRC_DATA(src_data), .SRC_VALID(src_valid),
    .SRC_READY(src_ready), .INTR(intr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic [7:0] p, input logic [7:0] exp);
    port_id = p;
    #1;
    check_eq(tag, in_data, exp);
    port_id = 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    src_data  = b;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
  endtask

  task automatic ctrl(input logic [7:0] v);
    port_id  = 8'h32;
    out_port = v;
    io_strb  = 1'b1;
    tick();
    io_strb  = 1'b0;
    port_id  = 8'h00;
  endtask

  // Control write and source push on the same clock edge.
  task automatic ctrl_push(input logic [7:0] v, input logic [7:0] b);
    port_id   = 8'h32;
    out_port  = v;
    io_strb   = 1'b1;
    src_data  = b;
    src_valid = 1'b1;
    tick();
    io_strb   = 1'b0;
    src_valid = 1'b0;
    port_id   = 8'h00;
  endtask

  initial begin
    rst = 1'b1; port_id = 8'h00; out_port = 8'h00; io_strb = 1'b0;
    src_data = 8'h00; src_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state and decode
    chk_port("rst_status", 8'h31, 8'h40);
    port_id = 8'h31; #1;
    check_eq("hit_status", 8'(in_hit), 8'h01);
    port_id = 8'h20; #1;
    check_eq("miss_data", in_data, 8'h00);
    check_eq("miss_hit", 8'(in_hit), 8'h00);
    port_id = 8'h00;
    check_eq("rst_intr", 8'(intr), 8'h00);
    check_eq("rst_ready", 8'(src_ready), 8'h01);

    // Single push/pop with interrupts enabled
    ctrl(8'h08);
    check_eq("en_no_intr", 8'(intr), 8'h00);
    push(8'hA5);
    check_eq("push_intr", 8'(intr), 8'h01);
    tick();
    check_eq("intr_one_cycle", 8'(intr), 8'h00);
    chk_port("head_a5", 8'h30, 8'hA5);
    chk_port("status_1", 8'h31, 8'h11);
    ctrl(8'h09);
    check_eq("pop_last_no_intr", 8'(intr), 8'h00);
    chk_port("status_0", 8'h31, 8'h50);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk_port("status_full", 8'h31, 8'h98);
    check_eq("ready_full", 8'(src_ready), OVW ? 8'h01 : 8'h00);
    push(8'h09);
    chk_port("status_ovf", 8'h31, 8'hB8);
    check_eq("ready_ovf", 8'(src_ready), OVW ? 8'h01 : 8'h00);
    for (int i = 0; i < 8; i++) begin
      chk_port($sformatf("drain_%0d", i), 8'h30, 8'((OVW ? 2 : 1) + i));
      ctrl(8'h09);
      if (i == 0) check_eq("pop_intr", 8'(intr), 8'h01);
    end
    check_eq("drain_last_intr", 8'(intr), 8'h00);
    chk_port("status_drained", 8'h31, 8'h70);
    ctrl(8'h02);
    chk_port("status_clr", 8'h31, 8'h40);

    // Flush + pop + push on one edge: flush wins
    ctrl(8'h08);
    push(8'h11); push(8'h22); push(8'h33);
    chk_port("status_3", 8'h31, 8'h13);
    ctrl_push(8'h05, 8'h77);
    check_eq("flush_no_intr", 8'(intr), 8'h00);
    chk_port("status_flush", 8'h31, 8'h40);
    chk_port("head_flush", 8'h30, 8'h00);

    // Empty + push + pop: push only
    ctrl(8'h08);
    ctrl_push(8'h09, 8'h5A);
    check_eq("empty_pp_intr", 8'(intr), 8'h01);
    chk_port("empty_pp_status", 8'h31, 8'h11);
    chk_port("empty_pp_head", 8'h30, 8'h5A);
    // Non-empty push + pop: count unchanged
    push(8'h6B);
    check_eq("push_nonempty_intr", 8'(intr), 8'h00);
    ctrl_push(8'h09, 8'h7C);
    check_eq("pp_intr", 8'(intr), 8'h01);
    chk_port("pp_status", 8'h31, 8'h12);
    chk_port("pp_head", 8'h30, 8'h6B);
    // Pop on empty is ignored
    ctrl(8'h01); ctrl(8'h01); ctrl(8'h01);
    chk_port("pop_empty_status", 8'h31, 8'h40);

    // Clear overflow and new overflow on the same edge
    ctrl(8'h08);
    for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
    push(8'hC8);
    chk_port("ovf2_status", 8'h31, 8'hB8);
    ctrl_push(8'h0A, 8'hC9);
    chk_port("clr_and_ovf", 8'h31, 8'hB8);
    ctrl(8'h0A);
    chk_port("clr_only", 8'h31, 8'h98);

    // Wrapped pointers, then reset with push and pop pending
    for (int i = 0; i < 6; i++) ctrl(8'h09);
    chk_port("wrap_status", 8'h31, 8'h12);
    chk_port("wrap_head", 8'h30, OVW ? 8'hC8 : 8'hC6);
    rst = 1'b1;
    ctrl_push(8'h09, 8'hEE);
    rst = 1'b0;
    check_eq("reset_intr", 8'(intr), 8'h00);
    chk_port("reset_status", 8'h31, 8'h40);
    chk_port("reset_head", 8'h30, 8'h00);
    check_eq("reset_ready", 8'(src_ready), 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
